// File: rtl/nanov_alu_pkg.sv
// rtl/nanov_alu_pkg.sv - shared opcodes, FSM state type and clog2 helper for the sequential nanoV ALU
package nanov_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SR   = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARITH = 2'd1,
    SHIFT = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/nanov_alu_digit.sv
// rtl/nanov_alu_digit.sv - one DIGIT_W-bit slice of the add/sub/logic datapath
module nanov_alu_digit
  import nanov_alu_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [2:0]         op,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a_dig,
  input  logic [DIGIT_W-1:0] b_dig,
  input  logic               cin,
  output logic [DIGIT_W-1:0] r_dig,
  output logic               cout
);

  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W:0]   sum;

  // Subtraction is A + ~B + carry; logic ops ignore the adder entirely.
  always_comb begin
    b_eff = sub ? ~b_dig : b_dig;
    sum   = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
    cout  = sum[DIGIT_W];
    case (op)
      OP_XOR:  r_dig = a_dig ^ b_dig;
      OP_OR:   r_dig = a_dig | b_dig;
      OP_AND:  r_dig = a_dig & b_dig;
      default: r_dig = sum[DIGIT_W-1:0];
    endcase
  end

endmodule

// File: rtl/nanov_alu_seq.sv
// rtl/nanov_alu_seq.sv - multi-cycle RV32I register ALU with start/busy/done handshake and flush
module nanov_alu_seq
  import nanov_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic            alt,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] d
);

  localparam int NDIG = XLEN / DIGIT_W;
  localparam int SHW  = clog2(XLEN);
  // Wide enough for both the digit index and a shift count of XLEN-1.
  localparam int CW   = clog2(XLEN) + 1;

  state_t state, state_next;

  logic [2:0]      op_r;
  logic            alt_r;
  logic            sub_r;
  logic            carry;
  logic            sa, sb;
  logic [XLEN-1:0] a_sr;
  logic [XLEN-1:0] b_sr;
  logic [XLEN-1:0] acc;
  logic [CW-1:0]   cnt;

  logic            capture, finish;
  logic            is_shift_op, sub_op;
  logic [DIGIT_W-1:0] r_dig;
  logic            cout;
  logic [XLEN-1:0] r_ext, acc_next, shift_1;
  logic            fill, lt;

  nanov_alu_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .op    (op_r),
    .sub   (sub_r),
    .a_dig (a_sr[DIGIT_W-1:0]),
    .b_dig (b_sr[DIGIT_W-1:0]),
    .cin   (carry),
    .r_dig (r_dig),
    .cout  (cout)
  );

  assign busy = (state != IDLE);

  // Next-state logic: flush overrides everything, including a same-cycle start.
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    finish      = 1'b0;
    is_shift_op = (op == OP_SLL) || (op == OP_SR);
    sub_op      = ((op == OP_ADD) && alt) || (op == OP_SLT) || (op == OP_SLTU);
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            capture    = 1'b1;
            state_next = is_shift_op ? SHIFT : ARITH;
          end
        end
        ARITH: begin
          if (cnt == CW'(NDIG - 1)) begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
        SHIFT: begin
          if (cnt <= CW'(1)) begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Per-cycle datapath values: next accumulator, one-bit shift and the compare result.
  always_comb begin
    r_ext    = XLEN'(r_dig);
    acc_next = (acc >> DIGIT_W) | (r_ext << (XLEN - DIGIT_W));
    fill     = alt_r & a_sr[XLEN-1];
    shift_1  = (op_r == OP_SLL) ? (a_sr << 1) : {fill, a_sr[XLEN-1:1]};
    // Bit XLEN of {sa,A} + {~sb,~B} + 1, given the carry out of the low XLEN bits.
    lt       = sa ^ ~sb ^ cout;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Operand capture, digit/shift stepping and result writeback.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_r  <= '0;
      alt_r <= 1'b0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      d     <= '0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        op_r  <= op;
        alt_r <= alt;
        sub_r <= sub_op;
        carry <= sub_op;
        sa    <= (op == OP_SLT) & a[XLEN-1];
        sb    <= (op == OP_SLT) & b[XLEN-1];
        a_sr  <= a;
        b_sr  <= b;
        acc   <= '0;
        cnt   <= is_shift_op ? CW'(b[SHW-1:0]) : '0;
      end else if (state == ARITH && !flush) begin
        a_sr  <= a_sr >> DIGIT_W;
        b_sr  <= b_sr >> DIGIT_W;
        acc   <= acc_next;
        carry <= cout;
        cnt   <= cnt + CW'(1);
        if (finish) begin
          done <= 1'b1;
          d    <= ((op_r == OP_SLT) || (op_r == OP_SLTU)) ? XLEN'(lt) : acc_next;
        end
      end else if (state == SHIFT && !flush) begin
        if (cnt != '0) begin
          a_sr <= shift_1;
          cnt  <= cnt - CW'(1);
        end
        if (finish) begin
          done <= 1'b1;
          d    <= (cnt == '0) ? a_sr : shift_1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nanov_alu_seq.sv
// tb/tb_nanov_alu_seq.sv - self-checking bench for nanov_alu_seq at DIGIT_W 4, 1, 8 and 32
module tb_nanov_alu_seq;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        alt   = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;

  logic        busy_v [4];
  logic        done_v [4];
  logic [31:0] d_v    [4];

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DW = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 32;
    nanov_alu_seq #(.XLEN(32), .DIGIT_W(DW)) u_dut (
      .clk   (clk),
      .rstn  (rstn),
      .start (start),
      .flush (flush),
      .op    (op),
      .alt   (alt),
      .a     (a),
      .b     (b),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .d     (d_v[g])
    );
  end

  function automatic int dw(input int i);
    case (i)
      0: return 4;
      1: return 1;
      2: return 8;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] o, input logic al,
                                          input logic [31:0] x, input logic [31:0] y);
    int unsigned sh;
    sh = y[4:0];
    case (o)
      3'd0: return al ? x - y : x + y;
      3'd1: return x << sh;
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return al ? 32'($signed(x) >>> sh) : x >> sh;
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick;
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op to all four DUTs and check value plus busy/done timing per DUT.
  task automatic run_op(input string tag, input logic [2:0] o, input logic al,
                        input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] exp;
    int          lat [4];
    int          maxlat;
    logic        ok  [4];
    logic [31:0] got [4];
    exp    = ref_alu(o, al, av, bv);
    maxlat = 0;
    for (int i = 0; i < 4; i++) begin
      if (o == 3'd1 || o == 3'd5) lat[i] = (bv[4:0] == 5'd0) ? 1 : int'(bv[4:0]);
      else                        lat[i] = 32 / dw(i);
      if (lat[i] > maxlat) maxlat = lat[i];
      ok[i]  = 1'b1;
      got[i] = 'x;
    end
    op = o; alt = al; a = av; b = bv; start = 1'b1;
    tick;
    start = 1'b0;
    op = 3'($urandom); alt = 1'($urandom); a = $urandom; b = $urandom;
    for (int c = 0; c <= maxlat; c++) begin
      if (c > 0) tick;
      for (int i = 0; i < 4; i++) begin
        if (c < lat[i]) begin
          if (busy_v[i] !== 1'b1 || done_v[i] !== 1'b0) ok[i] = 1'b0;
        end else if (c == lat[i]) begin
          if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b1) ok[i] = 1'b0;
          got[i] = d_v[i];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s dw%0d value", tag, dw(i)), got[i], exp);
      check($sformatf("%s dw%0d timing", tag, dw(i)), 32'(ok[i]), 32'd1);
    end
  endtask

  // Directed sequence followed by randomized ops against the reference model.
  initial begin
    int n;
    logic saw_done;
    #1 rstn = 1'b0;
    repeat (3) tick;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset busy dw%0d", dw(i)), 32'(busy_v[i]), 32'd0);
      check($sformatf("reset done dw%0d", dw(i)), 32'(done_v[i]), 32'd0);
      check($sformatf("reset d dw%0d", dw(i)), d_v[i], 32'd0);
    end
    rstn = 1'b1;
    tick;

    run_op("add_ovf", 3'd0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    run_op("slt",     3'd2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("sltu",    3'd3, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("sub",     3'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("sub_neg", 3'd0, 1'b1, 32'h0000_0000, 32'h0000_0001);
    run_op("sra4",    3'd5, 1'b1, 32'h8000_0000, 32'h0000_0004);
    run_op("srl4",    3'd5, 1'b0, 32'h8000_0000, 32'h0000_0004);
    run_op("sll31",   3'd1, 1'b0, 32'h0000_0001, 32'h0000_001F);
    run_op("shamt0",  3'd1, 1'b0, 32'h1234_5678, 32'h0000_0020);

    // Start while busy is ignored; only the DW=4 instance is tracked here.
    op = 3'd0; alt = 1'b0; a = 32'd5; b = 32'd6; start = 1'b1;
    tick;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      start = (c == 3);
      if (c == 3) begin a = 32'd100; b = 32'd200; end
      tick;
      start = 1'b0;
      if (done_v[0] === 1'b1) begin n = c; break; end
    end
    check("hs_ignored latency", 32'(n), 32'd8);
    check("hs_ignored value", d_v[0], 32'd11);

    // Start in the done cycle is taken immediately.
    op = 3'd0; a = 32'd1; b = 32'd2; start = 1'b1;
    tick;
    start = 1'b0;
    check("hs_b2b busy", 32'(busy_v[0]), 32'd1);

    // Flush that op at cycle 5: no done, d keeps the previous result.
    repeat (4) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush busy", 32'(busy_v[0]), 32'd0);
    check("flush done", 32'(done_v[0]), 32'd0);
    saw_done = 1'b0;
    repeat (10) begin
      tick;
      if (done_v[0] !== 1'b0) saw_done = 1'b1;
    end
    check("flush no_done", 32'(saw_done), 32'd0);
    check("flush d_held", d_v[0], 32'd11);

    // Flush and start together while idle: flush wins.
    op = 3'd0; start = 1'b1; flush = 1'b1;
    tick;
    start = 1'b0; flush = 1'b0;
    check("flush_start busy", 32'(busy_v[0]), 32'd0);

    // Asynchronous reset in the middle of a long shift.
    op = 3'd1; alt = 1'b0; a = 32'd1; b = 32'd31; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    check("mid_shift busy", 32'(busy_v[0]), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst busy", 32'(busy_v[0]), 32'd0);
    check("async_rst done", 32'(done_v[0]), 32'd0);
    check("async_rst d", d_v[0], 32'd0);
    tick;
    tick;
    rstn = 1'b1;
    tick;
    run_op("and", 3'd7, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);

    for (int k = 0; k < 500; k++) begin
      logic [2:0]  ro;
      logic        ral;
      logic [31:0] ra, rb;
      ro  = 3'($urandom_range(0, 7));
      ral = 1'($urandom);
      ra  = pick();
      rb  = pick();
      run_op($sformatf("rnd%0d op%0d alt%0d", k, ro, ral), ro, ral, ra, rb);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
